// File: rtl/lsu_mem.sv
//==============================================================================
// Module      : lsu_mem
// Description : Load/store unit between the execute and writeback stages.
//               Non-memory results pass straight to writeback with one cycle
//               of latency. LDW/SVW issue a held request on the data-memory
//               port. A wait counter aborts an access that is never
//               acknowledged and signals the abort with a one-cycle err pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYC   : cycles mem_req may stay high without mem_ack (>= 1)
// Optional feature (compile-time macro)
//   LSU_ALIGN_CHK_EN : when defined, a misaligned LDW/SVW (ex_result[1:0]!=0)
//                      is accepted and dropped with an err pulse, and no
//                      memory request is made
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   ex_valid / ex_ready     : handshake with the execute stage
//   ex_alu_op               : opcode (`ALO_LDW, `ALO_SVW, others)
//   ex_result               : address for LDW/SVW, final value otherwise
//   ex_store_data           : SVW store data
//   ex_rd_idx               : destination register index
//   mem_req/we/addr/wdata   : data-memory request, held until ack/timeout
//   mem_ack / mem_rdata     : memory completion and read data
//   wb_valid / wb_ready     : handshake with the writeback stage
//   wb_rd_idx / wb_data     : writeback destination and value
//   err                     : one-cycle pulse on an aborted access
//==============================================================================
`default_nettype none

`ifndef OPC_BIT
`define OPC_BIT [5:0]
`endif
`ifndef GPR_BIT
`define GPR_BIT [31:0]
`endif
`ifndef ALO_LDW
`define ALO_LDW 6'h20
`endif
`ifndef ALO_SVW
`define ALO_SVW 6'h21
`endif

module lsu_mem #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic `OPC_BIT ex_alu_op,
    input  logic `GPR_BIT ex_result,
    input  logic `GPR_BIT ex_store_data,
    input  logic [4:0]    ex_rd_idx,
    output logic          mem_req,
    output logic          mem_we,
    output logic `GPR_BIT mem_addr,
    output logic `GPR_BIT mem_wdata,
    input  logic          mem_ack,
    input  logic `GPR_BIT mem_rdata,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [4:0]    wb_rd_idx,
    output logic `GPR_BIT wb_data,
    output logic          err
);

    // Counter value seen in the last permitted un-acked ACCESS cycle; the
    // increment out of that cycle is the one that reaches TIMEOUT_CYC.
    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_cnt;
    logic          r_we;
    logic `GPR_BIT r_addr;
    logic `GPR_BIT r_wdata;
    logic `GPR_BIT r_wb_data;
    logic [4:0]    r_rd_idx;
    logic          r_err;

    logic          w_is_mem;
    logic          w_misalign;
    logic          w_start_mem;
    logic          w_start_alu;
    logic          w_done_ld;
    logic          w_timeout;
    logic          w_align_err;

    assign w_is_mem = (ex_alu_op == `ALO_LDW) || (ex_alu_op == `ALO_SVW);

`ifdef LSU_ALIGN_CHK_EN
    assign w_misalign = (ex_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and per-cycle event decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start_mem = 1'b0;
        w_start_alu = 1'b0;
        w_done_ld   = 1'b0;
        w_timeout   = 1'b0;
        w_align_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (w_is_mem) begin
                        if (w_misalign) begin
                            // Accepted but dropped; stay in IDLE.
                            w_align_err = 1'b1;
                        end else begin
                            w_start_mem = 1'b1;
                            w_state_nxt = S_ACCESS;
                        end
                    end else begin
                        w_start_alu = 1'b1;
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the timeout cycle takes priority over the abort.
                if (mem_ack) begin
                    if (r_we) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_done_ld   = 1'b1;
                        w_state_nxt = S_WB;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= 16'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
            r_rd_idx  <= 5'd0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_timeout | w_align_err;

            if (w_start_mem) begin
                r_cnt    <= 16'd0;
                r_we     <= (ex_alu_op == `ALO_SVW);
                r_addr   <= ex_result;
                r_wdata  <= ex_store_data;
                r_rd_idx <= ex_rd_idx;
            end else if ((r_state == S_ACCESS) && !mem_ack) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_start_alu) begin
                r_wb_data <= ex_result;
                r_rd_idx  <= ex_rd_idx;
            end else if (w_done_ld) begin
                r_wb_data <= mem_rdata;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign ex_ready  = (r_state == S_IDLE);
    assign mem_req   = (r_state == S_ACCESS);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign wb_valid  = (r_state == S_WB);
    assign wb_rd_idx = r_rd_idx;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem.sv
//==============================================================================
// Module      : tb_lsu_mem
// Description : Directed self-checking bench for lsu_mem (TIMEOUT_CYC = 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lsu_mem;

    localparam logic [5:0] c_OP_ADD = 6'h01;
    localparam logic [5:0] c_OP_LDW = 6'h20;
    localparam logic [5:0] c_OP_SVW = 6'h21;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_alu_op;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_idx;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem #(.TIMEOUT_CYC(4)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_op     (ex_alu_op),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd_idx     (ex_rd_idx),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd_idx     (wb_rd_idx),
        .wb_data       (wb_data),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] res,
                           input logic [31:0] sd, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu_op     = op;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd_idx     = rd;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_op = '0; ex_result = '0;
        ex_store_data = '0; ex_rd_idx = '0; mem_ack = 1'b0; mem_rdata = '0;
        wb_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_wb_data",  wb_data,       32'd0);
        rst_n = 1'b1;
        tick();

        // ADD result, one-cycle latency
        present(c_OP_ADD, 32'h5, 32'h0, 5'd3);
        wb_ready = 1'b1;
        chk("add_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_wb_data",  wb_data,       32'h5);
        chk("add_wb_rd",    32'(wb_rd_idx), 32'd3);
        chk("add_busy",     32'(ex_ready), 32'd0);
        tick();
        chk("add_done",     32'(wb_valid), 32'd0);
        chk("add_idle",     32'(ex_ready), 32'd1);

        // Writeback held while wb_ready=0, rd=0 passed through
        present(c_OP_ADD, 32'h77, 32'h0, 5'd0);
        wb_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        tick(); tick();
        chk("hold_wb_valid", 32'(wb_valid), 32'd1);
        chk("hold_wb_data",  wb_data,       32'h77);
        chk("hold_wb_rd",    32'(wb_rd_idx), 32'd0);
        wb_ready = 1'b1;
        tick();
        chk("hold_release",  32'(wb_valid), 32'd0);

        // LDW 0x100, ack three cycles after mem_req rises (timeout cycle)
        present(c_OP_LDW, 32'h100, 32'hAAAA_5555, 5'd7);
        tick();
        ex_valid = 1'b0;
        chk("ld_req",  32'(mem_req), 32'd1);
        chk("ld_we",   32'(mem_we),  32'd0);
        chk("ld_addr", mem_addr,     32'h100);
        tick(); tick(); tick();
        chk("ld_req_held",  32'(mem_req), 32'd1);
        chk("ld_addr_held", mem_addr,     32'h100);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("ld_req_drop", 32'(mem_req),  32'd0);
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_data",  wb_data,       32'hDEAD_BEEF);
        chk("ld_wb_rd",    32'(wb_rd_idx), 32'd7);
        chk("ld_tie_err",  32'(err),      32'd0);
        tick();
        chk("ld_idle", 32'(ex_ready), 32'd1);

        // SVW 0x200, ack after one cycle
        present(c_OP_SVW, 32'h200, 32'h1234_5678, 5'd9);
        tick();
        ex_valid = 1'b0;
        chk("st_we",    32'(mem_we),  32'd1);
        chk("st_wdata", mem_wdata,    32'h1234_5678);
        chk("st_addr",  mem_addr,     32'h200);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("st_req_drop", 32'(mem_req),  32'd0);
        chk("st_no_wb",    32'(wb_valid), 32'd0);
        chk("st_ready",    32'(ex_ready), 32'd1);

        // LDW timeout: mem_req for 4 cycles, then err pulse
        present(c_OP_LDW, 32'h300, 32'h0, 5'd4);
        tick();
        ex_valid = 1'b0;
        tick(); tick(); tick();
        chk("to_req_4th", 32'(mem_req), 32'd1);
        chk("to_err_pre", 32'(err),     32'd0);
        tick();
        chk("to_req_drop", 32'(mem_req),  32'd0);
        chk("to_err",      32'(err),      32'd1);
        chk("to_no_wb",    32'(wb_valid), 32'd0);
        chk("to_ready",    32'(ex_ready), 32'd1);
        tick();
        chk("to_err_once", 32'(err), 32'd0);

        // mem_ack outside ACCESS is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_req", 32'(mem_req),  32'd0);
        chk("stray_ack_wb",  32'(wb_valid), 32'd0);

        // Reset during ACCESS
        present(c_OP_LDW, 32'h400, 32'h0, 5'd2);
        tick();
        ex_valid = 1'b0;
        chk("rsta_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rsta_req_drop", 32'(mem_req),  32'd0);
        chk("rsta_ready",    32'(ex_ready), 32'd1);
        chk("rsta_err",      32'(err),      32'd0);
        chk("rsta_addr",     mem_addr,      32'd0);
        rst_n = 1'b1;
        tick();

        // Misaligned LDW 0x102
        present(c_OP_LDW, 32'h102, 32'h0, 5'd5);
        tick();
        ex_valid = 1'b0;
`ifdef LSU_ALIGN_CHK_EN
        chk("mis_req",   32'(mem_req),  32'd0);
        chk("mis_err",   32'(err),      32'd1);
        chk("mis_ready", 32'(ex_ready), 32'd1);
        tick();
        chk("mis_err_once", 32'(err),     32'd0);
        chk("mis_req_idle", 32'(mem_req), 32'd0);
`else
        chk("mis_req",  32'(mem_req), 32'd1);
        chk("mis_addr", mem_addr,     32'h102);
        chk("mis_err",  32'(err),     32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0;
        chk("mis_wb_data", wb_data, 32'hCAFE_0001);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum number of cycles mem_req stays high without mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage presents a result.
REQ-005 ex_ready  output  1  LSU accepts the execute result this cycle.
REQ-006 ex_alu_op  input  `OPC_BIT  ALU opcode of the result (`ALO_LDW`, `ALO_SVW`, others).
REQ-007 ex_result  input  `GPR_BIT  ALU rd_value: the address for LDW/SVW, the final value otherwise.
REQ-008 ex_store_data  input  `GPR_BIT  store data for SVW.
REQ-009 ex_rd_idx  input  5  destination register index.
REQ-010 mem_req  output  1  data-memory request, held until acknowledged or timed out.
REQ-011 mem_we  output  1  1 = write (SVW), 0 = read (LDW).
REQ-012 mem_addr  output  `GPR_BIT  byte address of the access.
REQ-013 mem_wdata  output  `GPR_BIT  write data.
REQ-014 mem_ack  input  1  memory completes the access this cycle; mem_rdata is valid for reads.
REQ-015 mem_rdata  input  `GPR_BIT  read data.
REQ-016 wb_valid  output  1  writeback value present.
REQ-017 wb_ready  input  1  writeback stage consumes the value.
REQ-018 wb_rd_idx  output  5  destination index.
REQ-019 wb_data  output  `GPR_BIT  value to write.
REQ-020 err  output  1  one-cycle pulse on an aborted access.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS and WB; ex_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE with ex_valid=1 and an op that is neither LDW nor SVW, the LSU SHALL latch ex_result and ex_rd_idx and enter WB, so that wb_valid=1 in the next cycle (1-cycle latency).
REQ-023 In IDLE with ex_valid=1 and op LDW or SVW, the LSU SHALL latch the address, store data, rd_idx and direction, and enter ACCESS; mem_req SHALL be 1 from the next cycle on.
REQ-024 In ACCESS, mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until the cycle in which mem_ack=1.
REQ-025 On mem_ack for a load, the LSU SHALL register mem_rdata into wb_data, drop mem_req and enter WB; wb_valid SHALL be 1 in the cycle after the ack.
REQ-026 On mem_ack for a store, the LSU SHALL drop mem_req and return to IDLE with no writeback.
REQ-027 A 16-bit wait counter SHALL clear on entry to ACCESS and increment on every cycle in ACCESS without mem_ack.
REQ-028 When the counter reaches TIMEOUT_CYC without mem_ack, the LSU SHALL drop mem_req, pulse err for one cycle, discard the access (no writeback) and return to IDLE.
REQ-029 If mem_ack arrives in the same cycle as the timeout, the ack SHALL win and no err pulse SHALL be generated.
REQ-030 In WB, wb_valid, wb_data and wb_rd_idx SHALL be held until wb_ready=1; in that cycle the LSU SHALL return to IDLE.
REQ-031 The LSU SHALL treat rd_idx 0 like any other index; suppressing r0 writes is the job of the writeback stage.
REQ-032 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-033 With rst_n=0 at a rising edge, the next state SHALL be IDLE and mem_req, mem_we, wb_valid and err SHALL be 0; mem_addr, mem_wdata, wb_data, wb_rd_idx and the counter SHALL be 0.
REQ-034 A reset during ACCESS or WB SHALL abort the operation without an err pulse; mem_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-035 Macro LSU_ALIGN_CHK_EN: when defined, an LDW/SVW with ex_result[1:0]!=0 SHALL be accepted, cause no memory request, pulse err for one cycle and leave the LSU in IDLE; when not defined, no alignment check takes place and the address goes unchanged to mem_addr.

Verification
REQ-036 ADD result: ex_result=0x0000_0005, rd=3, wb_ready=1 -> wb_valid=1 with wb_data=0x5, wb_rd_idx=3 exactly one cycle after acceptance.
REQ-037 LDW addr=0x100, mem_ack three cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_we=0, mem_addr=0x100 stable, wb_data=0xDEADBEEF in the cycle after the ack.
REQ-038 SVW addr=0x200, data=0x12345678, ack after one cycle -> mem_we=1, mem_wdata=0x12345678, no wb_valid, ex_ready=1 again in the cycle after the ack.
REQ-039 LDW with TIMEOUT_CYC=4, no mem_ack -> mem_req drops after 4 cycles, err=1 for one cycle, no wb_valid; ack and timeout in the same cycle -> normal completion, err=0.
REQ-040 rst_n=0 while mem_req=1 -> mem_req=0 and ex_ready=1 in the next cycle, err=0.
REQ-041 With LSU_ALIGN_CHK_EN: LDW addr=0x102 -> mem_req remains 0 and err pulses once; without the macro -> mem_req=1, mem_addr=0x102.
